// File: rtl/fifo_rr_burst_arbiter_if.sv
`default_nettype none
// ============================================================================
// fifo_rr_burst_arbiter_if : source-FIFO bank and output-stream bundle
// Revision: 1.0
// ============================================================================
interface fifo_rr_burst_arbiter_if #(
  parameter int C_NUM_SRC    = 4,
  parameter int C_DATA_WIDTH = 128
);
  logic [C_NUM_SRC-1:0]              src_empty;
  logic [18*C_NUM_SRC-1:0]           src_count;
  logic [C_DATA_WIDTH*C_NUM_SRC-1:0] src_data;
  logic [C_NUM_SRC-1:0]              src_mask;
  logic [C_NUM_SRC-1:0]              src_rden;
  logic [C_DATA_WIDTH-1:0]           out_data;
  logic                              out_valid;
  logic                              out_ready;
  logic                              out_last;
  logic [2:0]                        out_src;
  logic [C_NUM_SRC-1:0]              grant;

  modport master (
    input  src_empty, src_count, src_data, src_mask, out_ready,
    output src_rden, out_data, out_valid, out_last, out_src, grant
  );

  modport slave (
    output src_empty, src_count, src_data, src_mask, out_ready,
    input  src_rden, out_data, out_valid, out_last, out_src, grant
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// fifo_rr_burst_arbiter : round-robin burst drain of FWFT FIFOs into one stream
// Revision: 1.0
// ============================================================================
module fifo_rr_burst_arbiter #(
  parameter int C_NUM_SRC    = 4,
  parameter int C_DATA_WIDTH = 128,
  parameter int C_BURST_LEN  = 8,
  parameter int C_MIN_COUNT  = 1
) (
  input  wire logic               clk,
  input  wire logic               rst,
  fifo_rr_burst_arbiter_if.master bus
);
  localparam logic [17:0] MIN_CNT  = 18'(C_MIN_COUNT);
  localparam logic [7:0]  BEAT_MAX = 8'(C_BURST_LEN - 1);
  localparam logic [2:0]  LAST_IDX = 3'(C_NUM_SRC - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [C_NUM_SRC-1:0]   grant_q, grant_d;
  logic [2:0]             out_src_q, out_src_d;
  logic [2:0]             rr_ptr_q, rr_ptr_d;
  logic [7:0]             beat_q, beat_d;

  logic [C_NUM_SRC-1:0]    elig;
  logic [C_NUM_SRC-1:0]    rot;
  logic                    win_found;
  logic [2:0]              win_idx;
  logic [3:0]              sum;
  logic                    sel_empty;
  logic [17:0]             sel_count;
  logic [C_DATA_WIDTH-1:0] sel_data;
  logic                    valid;
  logic                    last;
  logic                    xfer;
  logic [2:0]              next_ptr;

  for (genvar gi = 0; gi < C_NUM_SRC; gi++) begin : g_elig
    assign elig[gi] = bus.src_mask[gi] & ~bus.src_empty[gi] &
                      (bus.src_count[18*gi +: 18] >= MIN_CNT);
  end

  // Rotating the eligibility vector by rr_ptr turns the wrap-around scan
  // into a plain lowest-set-bit search.
  always_comb begin
    rot       = C_NUM_SRC'({elig, elig} >> rr_ptr_q);
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    for (int k = 0; k < C_NUM_SRC; k++) begin
      if (!win_found && rot[k]) begin
        win_found = 1'b1;
        sum       = {1'b0, rr_ptr_q} + 4'(k);
        if (sum >= 4'(C_NUM_SRC)) sum = sum - 4'(C_NUM_SRC);
        win_idx   = sum[2:0];
      end
    end
  end

  always_comb begin
    sel_empty = 1'b1;
    sel_count = '0;
    sel_data  = '0;
    for (int i = 0; i < C_NUM_SRC; i++) begin
      if (out_src_q == 3'(i)) begin
        sel_empty = bus.src_empty[i];
        sel_count = bus.src_count[18*i +: 18];
        sel_data  = bus.src_data[C_DATA_WIDTH*i +: C_DATA_WIDTH];
      end
    end
  end

  assign valid    = ~rst & (state_q == ST_BURST) & ~sel_empty;
  assign last     = valid & ((beat_q == BEAT_MAX) | (sel_count == 18'd1));
  assign xfer     = valid & bus.out_ready;
  assign next_ptr = (out_src_q == LAST_IDX) ? 3'd0 : out_src_q + 3'd1;

  assign bus.out_valid = valid;
  assign bus.out_last  = last;
  assign bus.out_data  = sel_data;
  assign bus.src_rden  = xfer ? grant_q : '0;
  assign bus.out_src   = out_src_q;
  assign bus.grant     = grant_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    out_src_d = out_src_q;
    rr_ptr_d  = rr_ptr_q;
    beat_d    = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d   = ST_BURST;
          out_src_d = win_idx;
          beat_d    = '0;
          for (int i = 0; i < C_NUM_SRC; i++) grant_d[i] = (win_idx == 3'(i));
        end
      end
      ST_BURST: begin
        // An underrun ends the burst exactly like a final beat, minus the pop.
        if (sel_empty || (xfer && last)) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end else if (xfer) begin
          beat_d = beat_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      out_src_q <= '0;
      rr_ptr_q  <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      out_src_q <= out_src_d;
      rr_ptr_q  <= rr_ptr_d;
      beat_q    <= beat_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fifo_rr_burst_arbiter : directed + random bench with a burst-level model
// Revision: 1.0
// ============================================================================
module tb_fifo_rr_burst_arbiter;
  localparam int N    = 4;
  localparam int W    = 32;
  localparam int BL   = 8;
  localparam int MINC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rr_burst_arbiter_if #(.C_NUM_SRC(N), .C_DATA_WIDTH(W)) bus ();

  fifo_rr_burst_arbiter #(
    .C_NUM_SRC(N), .C_DATA_WIDTH(W), .C_BURST_LEN(BL), .C_MIN_COUNT(MINC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [2:0]   src;
    logic [W-1:0] data;
    logic         last;
    logic         first;
  } beat_t;

  logic [W-1:0] q [N][$];
  beat_t        exp_q[$];
  logic [N-1:0] mask;
  logic [N-1:0] force_empty;
  int m_rr, n_tests, n_fail, cyc, prev_last_cyc, xfers, stall_cnt, mode;
  int xf [N];

  logic [N-1:0] s_rden, s_grant;
  logic         s_valid, s_last;
  logic [2:0]   s_src;
  logic [W-1:0] s_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      bus.src_empty[i]          = (q[i].size() == 0) || force_empty[i];
      bus.src_count[18*i +: 18] = 18'(q[i].size());
      bus.src_data[W*i +: W]    = (q[i].size() > 0) ? q[i][0] : '0;
    end
    bus.src_mask = mask;
  endtask

  task automatic fill(input int s, input int n);
    for (int j = 0; j < n; j++) q[s].push_back($urandom);
  endtask

  // Burst-level prediction: with no pushes during a run, the grant order and
  // burst lengths follow from occupancies, mask and the rotation pointer alone.
  task automatic plan();
    int c [N];
    int off [N];
    int rr, pick, n;
    bit found;
    beat_t b;
    rr = m_rr;
    for (int i = 0; i < N; i++) begin
      c[i]   = q[i].size();
      off[i] = 0;
    end
    for (int g = 0; g < 1000; g++) begin
      found = 0;
      pick  = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && mask[(rr + k) % N] && c[(rr + k) % N] >= MINC && c[(rr + k) % N] > 0) begin
          found = 1;
          pick  = (rr + k) % N;
        end
      end
      if (!found) break;
      n = (c[pick] < BL) ? c[pick] : BL;
      for (int j = 0; j < n; j++) begin
        b.src   = 3'(pick);
        b.data  = q[pick][off[pick] + j];
        b.last  = (j == n - 1);
        b.first = (j == 0);
        exp_q.push_back(b);
      end
      off[pick] += n;
      c[pick]   -= n;
      rr = (pick + 1) % N;
    end
    m_rr = rr;
  endtask

  task automatic cycle_check();
    beat_t e;
    @(negedge clk);
    cyc++;
    s_rden  = bus.src_rden;
    s_grant = bus.grant;
    s_valid = bus.out_valid;
    s_last  = bus.out_last;
    s_src   = bus.out_src;
    s_data  = bus.out_data;
    if (s_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'(s_valid), 0);
      end else begin
        e = exp_q[0];
        chk("out_data", 64'(s_data), 64'(e.data));
        chk("out_last", 64'(s_last), 64'(e.last));
        chk("out_src", 64'(s_src), 64'(e.src));
        chk("grant", 64'(s_grant), 64'(1) << e.src);
        if (bus.out_ready) begin
          chk("src_rden", 64'(s_rden), 64'(1) << e.src);
          if (e.first && mode == 0 && prev_last_cyc >= 0)
            chk("burst_gap", 64'(cyc - prev_last_cyc), 2);
          if (e.last) prev_last_cyc = cyc;
          void'(exp_q.pop_front());
          xfers++;
          xf[e.src]++;
        end else begin
          chk("rden_stall", 64'(s_rden), 0);
        end
      end
    end else begin
      chk("rden_idle", 64'(s_rden), 0);
      chk("last_idle", 64'(s_last), 0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (s_rden[i] && q[i].size() > 0) void'(q[i].pop_front());
    case (mode)
      1: bus.out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (xfers == 3 && stall_cnt < 5) begin
          bus.out_ready = 1'b0;
          stall_cnt++;
        end else begin
          bus.out_ready = 1'b1;
        end
      end
      default: bus.out_ready = 1'b1;
    endcase
    drive_srcs();
  endtask

  task automatic run_stream(input int md);
    mode          = md;
    prev_last_cyc = -1;
    xfers         = 0;
    stall_cnt     = 0;
    bus.out_ready = (md == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    for (int g = 0; g < 3000 && exp_q.size() > 0; g++) cycle_check();
    chk("stream_drained", 64'(exp_q.size()), 0);
    cycle_check();
    cycle_check();
    chk("idle_grant", 64'(s_grant), 0);
    chk("idle_valid", 64'(s_valid), 0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; m_rr = 0; mode = 0;
    prev_last_cyc = -1; xfers = 0; stall_cnt = 0;
    for (int i = 0; i < N; i++) xf[i] = 0;
    mask          = '1;
    force_empty   = '0;
    bus.out_ready = 1'b1;
    drive_srcs();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 64'(bus.grant), 0);
    chk("rst_out_src", 64'(bus.out_src), 0);
    chk("rst_valid", 64'(bus.out_valid), 0);
    chk("rst_rden", 64'(bus.src_rden), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single source, 3 words: grant one cycle after arbitration, last on count==1
    fill(0, 3);
    drive_srcs();
    plan();
    cycle_check();
    chk("arb_cycle_grant", 64'(s_grant), 0);
    chk("arb_cycle_valid", 64'(s_valid), 0);
    cycle_check();
    chk("first_beat_grant", 64'(s_grant), 1);
    chk("first_beat_valid", 64'(s_valid), 1);
    cycle_check();
    cycle_check();
    chk("single_last", 64'(s_last), 1);
    cycle_check();
    chk("single_idle_grant", 64'(s_grant), 0);
    chk("single_drained", 64'(exp_q.size()), 0);

    // Burst cap and rotation between two deep sources
    fill(0, 20);
    fill(1, 20);
    drive_srcs();
    plan();
    run_stream(0);

    // Backpressure: 5 stalled cycles inside a src2 burst
    fill(2, 8);
    drive_srcs();
    plan();
    run_stream(2);
    chk("stall_cycles", 64'(stall_cnt), 5);

    // Mask and occupancy threshold
    mask = 4'b0111;
    fill(1, 1);
    fill(3, 6);
    drive_srcs();
    mode = 0;
    repeat (4) begin
      cycle_check();
      chk("masked_no_grant", 64'(s_grant), 0);
    end
    mask[3] = 1'b1;
    drive_srcs();
    plan();
    run_stream(0);
    chk("below_min_kept", 64'(q[1].size()), 1);
    fill(1, 1);
    drive_srcs();
    plan();
    run_stream(0);

    // Underrun after one beat of a 2-word src2 burst
    fill(2, 2);
    fill(3, 2);
    drive_srcs();
    begin
      beat_t b;
      b.src = 3'd2; b.data = q[2][0]; b.last = 1'b0; b.first = 1'b1;
      exp_q.push_back(b);
    end
    mode = 0;
    prev_last_cyc = -1;
    cycle_check();
    chk("ur_arb_grant", 64'(s_grant), 0);
    cycle_check();
    chk("ur_beat0_valid", 64'(s_valid), 1);
    force_empty[2] = 1'b1;
    drive_srcs();
    cycle_check();
    chk("ur_valid", 64'(s_valid), 0);
    chk("ur_last", 64'(s_last), 0);
    chk("ur_rden", 64'(s_rden), 0);
    chk("ur_grant_held", 64'(s_grant), 4);
    force_empty[2] = 1'b0;
    fill(2, 2);
    drive_srcs();
    m_rr = 3;
    plan();
    run_stream(0);

    // Reset on beat 3 of a src1 burst
    fill(0, 3);
    fill(1, 10);
    drive_srcs();
    plan();
    mode = 0;
    prev_last_cyc = -1;
    for (int i = 0; i < N; i++) xf[i] = 0;
    for (int g = 0; g < 100 && xf[1] < 3; g++) cycle_check();
    chk("rst_setup_beats", 64'(xf[1]), 3);
    rst = 1'b1;
    cycle_check();
    chk("rst_cycle_rden", 64'(s_rden), 0);
    chk("rst_cycle_valid", 64'(s_valid), 0);
    chk("rst_cycle_last", 64'(s_last), 0);
    rst = 1'b0;
    exp_q.delete();
    fill(0, 3);
    drive_srcs();
    m_rr = 0;
    plan();
    cycle_check();
    chk("post_rst_grant", 64'(s_grant), 0);
    chk("post_rst_src", 64'(s_src), 0);
    run_stream(0);

    // Randomized occupancies, masks and backpressure
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++) fill(i, $urandom_range(0, 20));
      mask = 4'($urandom_range(1, 15));
      drive_srcs();
      plan();
      run_stream(1);
      for (int i = 0; i < N; i++) q[i].delete();
      mask = '1;
      drive_srcs();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fifo_rr_burst_arbiter.md
# fifo_rr_burst_arbiter

Round-robin burst arbiter that drains up to C_NUM_SRC first-word-fall-through FIFOs into one shared output stream. It sits between a bank of per-channel FWFT FIFOs (empty/count/dataout/rden interface) and a single downstream consumer. It grants one source at a time and moves up to C_BURST_LEN words per grant. Bursts are bounded and rotation is fair, so no channel can monopolise the shared path.

## Interface
- C_NUM_SRC, 4, number of source FIFOs (2..8)
- C_DATA_WIDTH, 128, word width
- C_BURST_LEN, 8, maximum words per grant (1..256)
- C_MIN_COUNT, 1, minimum source occupancy required to win arbitration (>=1)
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- src_empty  input  C_NUM_SRC  per-source FWFT empty flag
- src_count  input  18*C_NUM_SRC  per-source occupancy; source i occupies bits [18*i+17:18*i]
- src_data  input  C_DATA_WIDTH*C_NUM_SRC  per-source FWFT head word, packed like src_count
- src_mask  input  C_NUM_SRC  1 = source may be granted (configuration)
- src_rden  output  C_NUM_SRC  per-source pop strobe, combinational
- out_data  output  C_DATA_WIDTH  head word of the granted source, combinational mux
- out_valid  output  1  out_data is valid this cycle
- out_ready  input  1  downstream accepts out_data this cycle
- out_last  output  1  current beat is the final beat of the burst
- out_src  output  3  index of the granted source, registered
- grant  output  C_NUM_SRC  one-hot grant, registered; all zero when idle

## Operation
- States: IDLE and BURST. Registers: state, grant, out_src, rr_ptr (3b), beat (8b).
- Eligibility of source i: src_mask[i] & ~src_empty[i] & (src_count[i] >= C_MIN_COUNT).
- IDLE: scan the sources in the order rr_ptr, rr_ptr+1, … wrapping modulo C_NUM_SRC. The first eligible source wins: grant and out_src are loaded, beat is cleared to 0, and the state moves to BURST. If no source is eligible, the block stays in IDLE.
- BURST, with sel = out_src:
  - out_valid = ~src_empty[sel].
  - out_data = src_data[sel].
  - Transfer = out_valid & out_ready. src_rden[sel] = transfer; every other src_rden bit is 0.
  - out_last = out_valid & ((beat == C_BURST_LEN-1) | (src_count[sel] == 1)).
  - On a transfer with out_last=1: go to IDLE, clear grant, set rr_ptr = sel+1 mod C_NUM_SRC.
  - On a transfer with out_last=0: beat += 1.
  - If src_empty[sel] is high in BURST (source underrun): go to IDLE the same way, without a pop and without out_last.
- src_mask changes during BURST do not abort the current burst; they take effect at the next arbitration.
- out_ready low: no pop. out_data and out_last are held stable because the FWFT head does not change without rden.
- In IDLE: out_valid=0, out_last=0, src_rden=0; out_data is don't-care.

## Timing
- Reset values: state=IDLE, grant=0, out_src=0, rr_ptr=0, beat=0.
- While rst is high, src_rden, out_valid and out_last are forced to 0 combinationally.
- Reset mid-burst aborts the burst. No pop occurs in the reset cycle.
- Arbitration latency: eligible at cycle t in IDLE → grant visible at t+1 → first beat possible at t+1.
- Inter-burst gap: last beat at cycle t → IDLE at t+1 (arbitrating) → next first beat at t+2. This is exactly one bubble cycle.
- Throughput within a burst is 1 word/cycle while out_ready=1 and the source is non-empty.
- A single source stays in a burst for at most C_BURST_LEN transfers.
- Worst-case wait for an eligible source: (C_NUM_SRC-1) bursts.
- Rotation rule: rr_ptr updates only at burst end, so a source that drains early still loses priority.
- beat width is 8 bits and compares against C_BURST_LEN-1. C_BURST_LEN=1 makes every beat last.

## Test plan
- Single source: src0 holds 3 words, C_BURST_LEN=8, out_ready=1 → grant=0001 one cycle after arbitration, 3 consecutive beats, out_last on the 3rd (count==1), then IDLE with grant=0.
- Burst cap with rotation: src0 holds 20 words and src1 holds 20 words → bursts alternate src0, src1, src0, …, 8 beats each, out_last on every 8th beat, one bubble between bursts.
- Backpressure: during a src2 burst, hold out_ready=0 for 5 cycles mid-burst → src_rden=0 and out_data unchanged for those cycles; the burst completes with the exact word order.
- Mask and threshold: C_MIN_COUNT=4, src1 count=3, src3 count=6 with src_mask[3]=0 → no grant. Set src_mask[3]=1 → src3 granted; src1 is granted only after its count reaches 4.
- Underrun: a source is granted with count=2 and src_empty then forced high after 1 beat → return to IDLE without out_last, rr_ptr advances past that source.
- Reset mid-burst: assert rst on beat 3 of a src1 burst → no src_rden in the reset cycle; next cycle grant=0, rr_ptr=0, and arbitration restarts from src0.
